// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one external-memory controller port between
// instruction fetch (port 0) and the load/store unit (port 1), one transaction in flight.
module mem_bus_arbiter #(
   parameter int ADDR_W  = 24,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic              req0_we,
   input  logic [31:0]       req0_wdata,
   output logic              req0_ack,
   output logic              req0_err,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic              req1_we,
   input  logic [31:0]       req1_wdata,
   output logic              req1_ack,
   output logic              req1_err,
   output logic [31:0]       rsp_rdata,
   output logic              mem_start,
   output logic              mem_abort,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_done
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              we;
      logic [31:0]       wdata;
   } mem_req_t;

   // Last WAIT cycle index before abort; timer counts WAIT edges from 0.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_e     state_q, state_d;
   logic       grant_q, grant_d;
   logic       last_grant_q, last_grant_d;
   logic [7:0] timer_q, timer_d;
   mem_req_t   req_q, req_d;
   logic       start_q, start_d;
   logic       abort_q, abort_d;
   logic [1:0] ack_q, ack_d;
   logic [1:0] err_q, err_d;
   logic [31:0] rdata_q, rdata_d;
   logic       sel;

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      timer_d      = timer_q;
      req_d        = req_q;
      rdata_d      = rdata_q;
      start_d      = 1'b0;
      abort_d      = 1'b0;
      ack_d        = 2'b00;
      err_d        = 2'b00;
      sel          = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req0_valid || req1_valid) begin
               // On a tie the port that did not win last time goes first.
               sel          = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
               grant_d      = sel;
               last_grant_d = sel;
               req_d        = sel ? '{addr: req1_addr, we: req1_we, wdata: req1_wdata}
                                  : '{addr: req0_addr, we: req0_we, wdata: req0_wdata};
               start_d      = 1'b1;
               timer_d      = 8'd0;
               state_d      = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_done) begin
               rdata_d        = mem_rdata;
               ack_d[grant_q] = 1'b1;
               state_d        = S_RESP;
            end else if (timer_q == TMO_LAST) begin
               abort_d        = 1'b1;
               err_d[grant_q] = 1'b1;
               state_d        = S_RESP;
            end else if (timer_q != 8'hFF) begin
               timer_d = timer_q + 8'd1;
            end
         end
         S_RESP: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         timer_q      <= 8'd0;
         req_q        <= '0;
         start_q      <= 1'b0;
         abort_q      <= 1'b0;
         ack_q        <= 2'b00;
         err_q        <= 2'b00;
         rdata_q      <= 32'd0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         timer_q      <= timer_d;
         req_q        <= req_d;
         start_q      <= start_d;
         abort_q      <= abort_d;
         ack_q        <= ack_d;
         err_q        <= err_d;
         rdata_q      <= rdata_d;
      end
   end

   assign req0_ack  = ack_q[0];
   assign req1_ack  = ack_q[1];
   assign req0_err  = err_q[0];
   assign req1_err  = err_q[1];
   assign rsp_rdata = rdata_q;
   assign mem_start = start_q;
   assign mem_abort = abort_q;
   assign mem_addr  = req_q.addr;
   assign mem_we    = req_q.we;
   assign mem_wdata = req_q.wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: arbitration order, timeout, done/timeout
// collision, stray completions and mid-transaction reset.
module tb_mem_bus_arbiter;
   localparam int ADDR_W  = 24;
   localparam int TIMEOUT = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req0_valid, req0_we, req0_ack, req0_err;
   logic [ADDR_W-1:0] req0_addr;
   logic [31:0]       req0_wdata;
   logic              req1_valid, req1_we, req1_ack, req1_err;
   logic [ADDR_W-1:0] req1_addr;
   logic [31:0]       req1_wdata;
   logic [31:0]       rsp_rdata, mem_wdata, mem_rdata;
   logic              mem_start, mem_abort, mem_we, mem_done;
   logic [ADDR_W-1:0] mem_addr;

   mem_bus_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_we(req0_we),
      .req0_wdata(req0_wdata), .req0_ack(req0_ack), .req0_err(req0_err),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_we(req1_we),
      .req1_wdata(req1_wdata), .req1_ack(req1_ack), .req1_err(req1_err),
      .rsp_rdata(rsp_rdata), .mem_start(mem_start), .mem_abort(mem_abort),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_done(mem_done)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Pulse monitors, sampled on the inactive edge
   int cyc = 0, n_ack0 = 0, n_ack1 = 0, n_err0 = 0, n_err1 = 0;
   int n_abort = 0, n_start = 0, n_clash = 0, last_start = 0, prev_start = 0;
   always @(negedge clk) begin
      cyc++;
      if (req0_ack) n_ack0++;
      if (req1_ack) n_ack1++;
      if (req0_err) n_err0++;
      if (req1_err) n_err1++;
      if (mem_abort) n_abort++;
      if (int'(req0_ack) + int'(req1_ack) + int'(req0_err) + int'(req1_err) > 1) n_clash++;
      if (mem_start) begin
         n_start++;
         prev_start = last_start;
         last_start = cyc;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Starts in IDLE with requests already driven; ends back in IDLE.
   task automatic run_txn(input int port, input logic [ADDR_W-1:0] addr, input logic we,
                          input logic [31:0] wd, input int d, input logic [31:0] rd,
                          input bit drop, input string tag);
      step();
      chk({tag, " start"}, 64'(mem_start), 64'd1);
      chk({tag, " addr"}, 64'(mem_addr), 64'(addr));
      chk({tag, " we"}, 64'(mem_we), 64'(we));
      chk({tag, " wdata"}, 64'(mem_wdata), 64'(wd));
      repeat (d) step();
      mem_done  = 1'b1;
      mem_rdata = rd;
      step();
      mem_done  = 1'b0;
      chk({tag, " ack0"}, 64'(req0_ack), (port == 0) ? 64'd1 : 64'd0);
      chk({tag, " ack1"}, 64'(req1_ack), (port == 1) ? 64'd1 : 64'd0);
      chk({tag, " err"}, {62'd0, req1_err, req0_err}, 64'd0);
      chk({tag, " abort"}, 64'(mem_abort), 64'd0);
      chk({tag, " start_low"}, 64'(mem_start), 64'd0);
      chk({tag, " rdata"}, 64'(rsp_rdata), 64'(rd));
      if (drop) begin
         req0_valid = 1'b0;
         req1_valid = 1'b0;
      end
      step();
      chk({tag, " ack_clear"}, {62'd0, req1_ack, req0_ack}, 64'd0);
   endtask

   initial begin
      req0_valid = 0; req0_addr = '0; req0_we = 0; req0_wdata = '0;
      req1_valid = 0; req1_addr = '0; req1_we = 0; req1_wdata = '0;
      mem_rdata = '0; mem_done = 0;

      // Reset state
      step();
      chk("rst start", 64'(mem_start), 64'd0);
      chk("rst addr", 64'(mem_addr), 64'd0);
      chk("rst rdata", 64'(rsp_rdata), 64'd0);
      chk("rst pulses", {60'd0, req1_err, req0_err, req1_ack, req0_ack}, 64'd0);
      rst = 1'b0;
      step();

      // 1: single fetch read, done 4 cycles after mem_start
      req0_valid = 1; req0_addr = 24'h000100;
      run_txn(0, 24'h000100, 1'b0, 32'd0, 4, 32'hDEADBEEF, 1, "t1");
      chk("t1 rdata_hold", 64'(rsp_rdata), 64'hDEADBEEF);

      // 2: both held from reset -> grant order 0,1,0, starts 3 cycles apart
      rst = 1'b1;
      req0_valid = 1; req0_addr = 24'h000200;
      req1_valid = 1; req1_addr = 24'h000300;
      step();
      rst = 1'b0;
      run_txn(0, 24'h000200, 1'b0, 32'd0, 0, 32'h11110000, 0, "t2a");
      run_txn(1, 24'h000300, 1'b0, 32'd0, 0, 32'h22220000, 0, "t2b");
      chk("t2 spacing01", 64'(last_start - prev_start), 64'd3);
      run_txn(0, 24'h000200, 1'b0, 32'd0, 0, 32'h33330000, 1, "t2c");
      chk("t2 spacing10", 64'(last_start - prev_start), 64'd3);

      // 3: LSU write
      req1_valid = 1; req1_addr = 24'h0000F0; req1_we = 1; req1_wdata = 32'h12345678;
      run_txn(1, 24'h0000F0, 1'b1, 32'h12345678, 2, 32'hA5A5A5A5, 1, "t3");
      req1_we = 0; req1_wdata = '0;

      // 4: timeout after 8 cycles, then a normal request
      req0_valid = 1; req0_addr = 24'h000400;
      step();
      chk("t4 start", 64'(mem_start), 64'd1);
      repeat (7) step();
      chk("t4 no_err_early", {62'd0, mem_abort, req0_err}, 64'd0);
      step();
      chk("t4 err0", 64'(req0_err), 64'd1);
      chk("t4 abort", 64'(mem_abort), 64'd1);
      chk("t4 no_ack", {62'd0, req1_ack, req0_ack}, 64'd0);
      chk("t4 rdata_kept", 64'(rsp_rdata), 64'hA5A5A5A5);
      req0_valid = 0;
      step();
      chk("t4 err_clear", {62'd0, mem_abort, req0_err}, 64'd0);
      req1_valid = 1; req1_addr = 24'h000500;
      run_txn(1, 24'h000500, 1'b0, 32'd0, 1, 32'h0BADF00D, 1, "t4b");

      // 5: done on the timeout cycle wins; stray done in IDLE ignored
      req0_valid = 1; req0_addr = 24'h000480;
      run_txn(0, 24'h000480, 1'b0, 32'd0, 7, 32'h5555AAAA, 1, "t5");
      mem_done = 1; mem_rdata = 32'hFFFFFFFF;
      step();
      step();
      chk("t5 stray_ack", {62'd0, req1_ack, req0_ack}, 64'd0);
      chk("t5 stray_rdata", 64'(rsp_rdata), 64'h5555AAAA);
      mem_done = 0;

      // 6: reset during WAIT, then both pending -> port 0 first
      req0_valid = 1; req0_addr = 24'h000600;
      step();
      step();
      chk("t6 wait_addr", 64'(mem_addr), 64'h600);
      #2 rst = 1'b1;
      req1_valid = 1; req1_addr = 24'h000700;
      #1;
      chk("t6 async_addr", 64'(mem_addr), 64'd0);
      chk("t6 async_rdata", 64'(rsp_rdata), 64'd0);
      step();
      chk("t6 rst_pulses", {59'd0, mem_abort, req1_err, req0_err, req1_ack, req0_ack}, 64'd0);
      rst = 1'b0;
      run_txn(0, 24'h000600, 1'b0, 32'd0, 1, 32'hCAFE0001, 0, "t6a");
      run_txn(1, 24'h000700, 1'b0, 32'd0, 1, 32'hCAFE0002, 1, "t6b");

      // Whole-run pulse totals
      step();
      chk("tot ack0", 64'(n_ack0), 64'd5);
      chk("tot ack1", 64'(n_ack1), 64'd4);
      chk("tot err0", 64'(n_err0), 64'd1);
      chk("tot err1", 64'(n_err1), 64'd0);
      chk("tot abort", 64'(n_abort), 64'd1);
      chk("tot start", 64'(n_start), 64'd11);
      chk("tot clash", 64'(n_clash), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
